// File: rtl/instr_decode.sv
// ----------------------------------------------------------------------------
// instr_decode
//   Single-stage instruction decoder for a 9-bit ISA. A fetched instruction is
//   accepted on a valid/ready handshake. It is split into type, opcode,
//   register indices, sign-extended immediate and write enables. The result is
//   held in one output register until the downstream side consumes it.
//   Accepting a branch FML (B op 3'b111) halts the decoder until reset.
//
//   Optional feature macro: DECODE_STATS_EN
//     When defined, adds the 16-bit wrapping counters stat_instr and
//     stat_branch. These count consumed bundles, and consumed branch bundles.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     upstream presents an instruction
//   in_ready     decoder accepts in_instr/in_pc this cycle (combinational)
//   in_instr     9-bit instruction word
//   in_pc        address of in_instr
//   flush        discard the pending bundle and the incoming instruction
//   out_valid    decoded bundle valid
//   out_ready    downstream consumes the bundle this cycle
//   out_type     I=0, M=1, R=2, B=3
//   out_op       opcode (M opcodes zero-extended, 0 for I)
//   out_rd       destination register (0 for B)
//   out_rs       source register (0 for I and B)
//   out_imm      sign-extended immediate / branch offset (0 for R and M)
//   out_pc       pc of the decoded instruction
//   out_reg_we   register-file write enable
//   out_mem_we   data-memory write enable
//   halted       FML has been accepted; decoder stopped
//   stat_instr   (DECODE_STATS_EN) bundles consumed
//   stat_branch  (DECODE_STATS_EN) branch bundles consumed
// ----------------------------------------------------------------------------
module instr_decode #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8:0]      in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_type,
    output logic [2:0]      out_op,
    output logic [1:0]      out_rd,
    output logic [1:0]      out_rs,
    output logic [7:0]      out_imm,
    output logic [PC_W-1:0] out_pc,
    output logic            out_reg_we,
    output logic            out_mem_we,
    output logic            halted
`ifdef DECODE_STATS_EN
    ,
    output logic [15:0]     stat_instr,
    output logic [15:0]     stat_branch
`endif
);

    localparam logic [1:0] TYPE_I = 2'd0;
    localparam logic [1:0] TYPE_M = 2'd1;
    localparam logic [1:0] TYPE_R = 2'd2;
    localparam logic [1:0] TYPE_B = 2'd3;

    localparam logic [1:0] M_OP_STR = 2'd1;
    localparam logic [2:0] B_OP_FML = 3'd7;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic            out_valid_q, out_valid_d;
    logic [1:0]      type_q, type_d;
    logic [2:0]      op_q, op_d;
    logic [1:0]      rd_q, rd_d;
    logic [1:0]      rs_q, rs_d;
    logic [7:0]      imm_q, imm_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            reg_we_q, reg_we_d;
    logic            mem_we_q, mem_we_d;

    // Decoded fields of the incoming word, before registering.
    logic [1:0] dec_type;
    logic [2:0] dec_op;
    logic [1:0] dec_rd;
    logic [1:0] dec_rs;
    logic [7:0] dec_imm;
    logic       dec_reg_we;
    logic       dec_mem_we;

    logic accept;
    logic handshake;

    // ---- combinational decode of in_instr ----
    always_comb begin
        dec_type   = in_instr[8:7];
        dec_op     = 3'd0;
        dec_rd     = 2'd0;
        dec_rs     = 2'd0;
        dec_imm    = 8'd0;
        dec_reg_we = 1'b0;
        dec_mem_we = 1'b0;
        unique case (dec_type)
            TYPE_I: begin
                dec_rd     = in_instr[6:5];
                dec_imm    = {{3{in_instr[4]}}, in_instr[4:0]};
                dec_reg_we = 1'b1;
            end
            TYPE_M: begin
                // in_instr[0] is a don't-care bit in the M format.
                dec_op     = {1'b0, in_instr[6:5]};
                dec_rd     = in_instr[4:3];
                dec_rs     = in_instr[2:1];
                dec_reg_we = (in_instr[6:5] != M_OP_STR);
                dec_mem_we = (in_instr[6:5] == M_OP_STR);
            end
            TYPE_R: begin
                dec_op     = in_instr[6:4];
                dec_rd     = in_instr[3:2];
                dec_rs     = in_instr[1:0];
                dec_reg_we = 1'b1;
            end
            TYPE_B: begin
                dec_op  = in_instr[6:4];
                dec_imm = {{4{in_instr[3]}}, in_instr[3:0]};
            end
            default: ;
        endcase
    end

    // ---- handshake, next-state and output register inputs ----
    always_comb begin
        in_ready    = !reset && (state_q == RUN) && !flush &&
                      (!out_valid_q || out_ready);
        accept      = in_valid && in_ready;
        // A bundle hit by flush in the same cycle is discarded, not consumed.
        handshake   = out_valid_q && out_ready && !flush;

        state_d     = state_q;
        out_valid_d = out_valid_q;
        type_d      = type_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rs_d        = rs_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        reg_we_d    = reg_we_q;
        mem_we_d    = mem_we_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            type_d      = dec_type;
            op_d        = dec_op;
            rd_d        = dec_rd;
            rs_d        = dec_rs;
            imm_d       = dec_imm;
            pc_d        = in_pc;
            reg_we_d    = dec_reg_we;
            mem_we_d    = dec_mem_we;
            if (dec_type == TYPE_B && dec_op == B_OP_FML) begin
                state_d = HALT;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ---- output register stage ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            type_q      <= 2'd0;
            op_q        <= 3'd0;
            rd_q        <= 2'd0;
            rs_q        <= 2'd0;
            imm_q       <= 8'd0;
            pc_q        <= '0;
            reg_we_q    <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            type_q      <= type_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            reg_we_q    <= reg_we_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_type   = type_q;
    assign out_op     = op_q;
    assign out_rd     = rd_q;
    assign out_rs     = rs_q;
    assign out_imm    = imm_q;
    assign out_pc     = pc_q;
    assign out_reg_we = reg_we_q;
    assign out_mem_we = mem_we_q;
    assign halted     = (state_q == HALT);

`ifdef DECODE_STATS_EN
    logic [15:0] stat_instr_q, stat_instr_d;
    logic [15:0] stat_branch_q, stat_branch_d;

    // Both counters wrap naturally at 16 bits.
    always_comb begin
        stat_instr_d  = stat_instr_q;
        stat_branch_d = stat_branch_q;
        if (handshake) begin
            stat_instr_d = stat_instr_q + 16'd1;
            if (type_q == TYPE_B) begin
                stat_branch_d = stat_branch_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_instr_q  <= 16'd0;
            stat_branch_q <= 16'd0;
        end else begin
            stat_instr_q  <= stat_instr_d;
            stat_branch_q <= stat_branch_d;
        end
    end

    assign stat_instr  = stat_instr_q;
    assign stat_branch = stat_branch_q;
`else
    // handshake only feeds the statistics counters.
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_instr_decode.sv
// ----------------------------------------------------------------------------
// tb_instr_decode
//   Self-checking bench for instr_decode. It keeps a reference model that
//   decodes words with plain arithmetic on the instruction value. The model
//   tracks the bundle, halt and statistics state, and is compared against the
//   DUT every cycle. Directed sections pin the model with literal
//   expectations. A randomized section follows them. With DECODE_STATS_EN, a
//   long BEQ stream exercises counter wrap.
// ----------------------------------------------------------------------------
module tb_instr_decode;

    localparam int PC_W = 8;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [8:0]      in_instr;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_type;
    logic [2:0]      out_op;
    logic [1:0]      out_rd;
    logic [1:0]      out_rs;
    logic [7:0]      out_imm;
    logic [PC_W-1:0] out_pc;
    logic            out_reg_we;
    logic            out_mem_we;
    logic            halted;
`ifdef DECODE_STATS_EN
    logic [15:0]     stat_instr;
    logic [15:0]     stat_branch;
`endif

    instr_decode #(.PC_W(PC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_type   (out_type),
        .out_op     (out_op),
        .out_rd     (out_rd),
        .out_rs     (out_rs),
        .out_imm    (out_imm),
        .out_pc     (out_pc),
        .out_reg_we (out_reg_we),
        .out_mem_we (out_mem_we),
        .halted     (halted)
`ifdef DECODE_STATS_EN
        ,
        .stat_instr (stat_instr),
        .stat_branch(stat_branch)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0] t;
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
        logic       rwe;
        logic       mwe;
    } bundle_t;

    function automatic bundle_t ref_decode(input logic [8:0] w);
        bundle_t b;
        int v, t, body, f;
        v    = int'(w);
        t    = v / 128;
        body = v % 128;
        b    = '0;
        b.t  = 2'(t);
        case (t)
            0: begin
                b.rd  = 2'(body / 32);
                f     = body % 32;
                b.imm = 8'((f >= 16) ? f + 224 : f);
                b.rwe = 1'b1;
            end
            1: begin
                f     = body / 32;
                b.op  = 3'(f);
                b.rd  = 2'((body / 8) % 4);
                b.rs  = 2'((body / 2) % 4);
                b.rwe = (f != 1);
                b.mwe = (f == 1);
            end
            2: begin
                b.op  = 3'(body / 16);
                b.rd  = 2'((body / 4) % 4);
                b.rs  = 2'(body % 4);
                b.rwe = 1'b1;
            end
            default: begin
                b.op  = 3'(body / 16);
                f     = body % 16;
                b.imm = 8'((f >= 8) ? f + 240 : f);
            end
        endcase
        return b;
    endfunction

    logic            m_valid  = 1'b0;
    logic            m_halted = 1'b0;
    bundle_t         m_b      = '0;
    logic [PC_W-1:0] m_pc     = '0;
    int              m_si     = 0;
    int              m_sb     = 0;

    // Advance the model on each edge from the inputs seen there, then compare.
    always begin
        logic rdy;
        bundle_t nb;
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_halted = 0; m_b = '0; m_pc = '0; m_si = 0; m_sb = 0;
        end else begin
            rdy = !m_halted && !flush && (!m_valid || out_ready);
            if (m_valid && out_ready && !flush) begin
                m_si = (m_si + 1) % 65536;
                if (m_b.t == 2'd3) m_sb = (m_sb + 1) % 65536;
            end
            if (flush) begin
                m_valid = 0;
            end else if (in_valid && rdy) begin
                nb      = ref_decode(in_instr);
                m_valid = 1;
                m_b     = nb;
                m_pc    = in_pc;
                if (nb.t == 2'd3 && nb.op == 3'd7) m_halted = 1;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("halted", halted, m_halted);
        chk("in_ready", in_ready,
            !reset && !m_halted && !flush && (!m_valid || out_ready));
        if (m_valid) begin
            chk("bundle", {out_type, out_op, out_rd, out_rs, out_imm, out_reg_we, out_mem_we}, m_b);
            chk("out_pc", out_pc, m_pc);
        end
`ifdef DECODE_STATS_EN
        chk("stat_instr", stat_instr, 16'(m_si));
        chk("stat_branch", stat_branch, 16'(m_sb));
`endif
    end

    // Drive inputs after the falling edge, return 2 time units past the next
    // rising edge so the registered effect of these inputs is visible.
    task automatic drv(input logic r, input logic v, input logic [8:0] ins,
                       input logic [PC_W-1:0] pc, input logic f, input logic o);
        @(negedge clk);
        reset = r; in_valid = v; in_instr = ins; in_pc = pc; flush = f; out_ready = o;
        @(posedge clk);
        #2;
    endtask

    localparam logic [8:0] W_ADD = 9'b10_000_01_10;
    localparam logic [8:0] W_I   = 9'b00_11_10000;
    localparam logic [8:0] W_STR = 9'b01_01_10_11_0;
    localparam logic [8:0] W_FML = 9'b11_111_0000;
    localparam logic [8:0] W_BEQ = 9'b11_001_0101;

    initial begin
        logic [8:0] w;
`ifdef DECODE_STATS_EN
        logic [15:0] snap_i, snap_b;
`endif
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;

        // Reset state, with in_valid high during reset.
        drv(1, 1, W_ADD, 8'h01, 0, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fields", {out_type, out_op, out_rd, out_rs, out_imm, out_pc, out_reg_we, out_mem_we}, 0);

        // R ADD rd1 rs2.
        drv(0, 1, W_ADD, 8'h10, 0, 1);
        chk("add_valid", out_valid, 1);
        chk("add_type", out_type, 2);
        chk("add_op", out_op, 0);
        chk("add_rd_rs", {out_rd, out_rs}, {2'd1, 2'd2});
        chk("add_reg_we", out_reg_we, 1);

        // I with negative immediate.
        drv(0, 1, W_I, 8'h05, 0, 1);
        chk("i_rd", out_rd, 3);
        chk("i_imm", out_imm, 8'hF0);
        chk("i_pc", out_pc, 8'h05);
        chk("i_reg_we", out_reg_we, 1);

        // M STR.
        drv(0, 1, W_STR, 8'h06, 0, 1);
        chk("str_op", out_op, 1);
        chk("str_we", {out_mem_we, out_reg_we}, 2'b10);

        // Backpressure for three cycles.
        for (int i = 0; i < 3; i++) begin
            drv(0, 1, W_ADD, 8'h20, 0, 0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold_pc", out_pc, 8'h06);
            chk("bp_hold_op", out_op, 1);
        end
        drv(0, 1, W_ADD, 8'h20, 0, 1);
        chk("bp_release_pc", out_pc, 8'h20);
        chk("bp_release_valid", out_valid, 1);

        // Flush with a valid bundle and a new instruction offered.
`ifdef DECODE_STATS_EN
        snap_i = stat_instr; snap_b = stat_branch;
`endif
        drv(0, 1, W_I, 8'h30, 1, 1);
        chk("flush_valid", out_valid, 0);
        drv(0, 0, W_I, 8'h31, 0, 1);
        chk("flush_nothing_taken", out_valid, 0);
`ifdef DECODE_STATS_EN
        chk("flush_stat_i", stat_instr, snap_i);
        chk("flush_stat_b", stat_branch, snap_b);
`endif

        // FML arriving together with flush is dropped.
        drv(0, 1, W_FML, 8'h41, 1, 1);
        chk("fml_flush_halted", halted, 0);
        chk("fml_flush_valid", out_valid, 0);

        // FML accepted: presented normally, then halt.
        drv(0, 1, W_FML, 8'h40, 0, 0);
        chk("fml_valid", out_valid, 1);
        chk("fml_type_op", {out_type, out_op}, {2'd3, 3'd7});
        chk("fml_halted", halted, 1);
        chk("fml_in_ready", in_ready, 0);
        drv(0, 1, W_ADD, 8'h50, 0, 1);
        chk("halt_drain", out_valid, 0);
        chk("halt_in_ready", in_ready, 0);
        drv(0, 1, W_ADD, 8'h51, 0, 1);
        chk("halt_no_accept", out_valid, 0);
        chk("halt_stays", halted, 1);
        drv(1, 1, W_ADD, 8'h52, 0, 1);
        chk("unhalt", halted, 0);
        drv(0, 1, W_ADD, 8'h60, 0, 1);
        chk("run_again_pc", out_pc, 8'h60);

        // Randomized traffic; FML is thinned out so the decoder mostly runs.
        for (int i = 0; i < 3000; i++) begin
            w = 9'($urandom_range(0, 511));
            if (w[8:4] == 5'b11111 && $urandom_range(0, 3) != 0) w[6] = 1'b0;
            drv(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), w,
                8'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
        end

`ifdef DECODE_STATS_EN
        // 65536 consumed BEQ bundles wrap both counters to zero.
        drv(1, 0, W_BEQ, 8'h00, 0, 1);
        for (int i = 0; i < 65536; i++) drv(0, 1, W_BEQ, 8'(i), 0, 1);
        drv(0, 0, W_BEQ, 8'h00, 0, 1);
        chk("wrap_stat_i", stat_instr, 16'd0);
        chk("wrap_stat_b", stat_branch, 16'd0);
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 Parameter PC_W, default 8, program-counter width carried alongside each instruction.
REQ-002 Clk  input  1  rising-edge clock; sole clock.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream holds a valid fetched instruction.
REQ-005 in_ready  output  1  decoder accepts in_instr/in_pc this cycle.
REQ-006 in_instr  input  9  instruction word.
REQ-007 in_pc  input  PC_W  address of in_instr.
REQ-008 flush  input  1  discard pending/incoming instruction (taken branch).
REQ-009 out_valid  output  1  decoded bundle valid.
REQ-010 out_ready  input  1  downstream consumes bundle this cycle.
REQ-011 out_type  output  2  Instr_Type: I=0, M=1, R=2, B=3.
REQ-012 out_op  output  3  R opcode (ADD..LSR = 0..7), M opcode (LDR,STR,MVA,MVS = 0..3, zero-extended), or B opcode (BAL..FML = 0..7); 0 for I.
REQ-013 out_rd, out_rs  output  2 each  destination/source register indices.
REQ-014 out_imm  output  8  sign-extended immediate/branch offset.
REQ-015 out_pc  output  PC_W  in_pc of decoded instruction.
REQ-016 out_reg_we, out_mem_we  output  1 each  register-file / data-memory write enables.
REQ-017 halted  output  1  decoder has retired FML and stopped.

Function
REQ-018 Decode format: [8:7] type; R: [6:4] op, [3:2] rd, [1:0] rs; M: [6:5] op, [4:3] rd, [2:1] rs, [0] ignored; I: [6:5] rd, [4:0] imm5; B: [6:4] op, [3:0] off4.
REQ-019 out_imm: I sign-extends imm5, B sign-extends off4, R/M drive 0; out_rs 0 for I/B, out_rd 0 for B.
REQ-020 out_reg_we = 1 for I, R, and M ops LDR/MVA/MVS; out_mem_we = 1 only for M op STR; both 0 for B.
REQ-021 Single output register stage: latency exactly 1 cycle from acceptance to out_valid.
REQ-022 in_ready = !halted && !flush && (!out_valid || out_ready), combinational.
REQ-023 Acceptance = in_valid && in_ready; bundle registered on that edge, out_valid set.
REQ-024 out_valid && !out_ready: all out_* fields held stable, no acceptance.
REQ-025 out_valid && out_ready && no acceptance: out_valid clears next cycle.
REQ-026 flush: out_valid = 0 next cycle, incoming instruction that cycle discarded; flush overrides out_ready and in_valid.
REQ-027 States RUN, HALT; RUN->HALT on acceptance of B op FML (3'b111); HALT exits only on Reset.
REQ-028 FML bundle itself presented normally; halted = 1 from the cycle after acceptance.
REQ-029 In HALT: in_ready = 0; pending bundle still drains via out_ready; flush still clears it.
REQ-030 flush in the same cycle as FML arrival: FML discarded, state remains RUN.

Reset
REQ-031 Reset (synchronous, active-high) overrides all inputs, including mid-handshake.
REQ-032 Reset values: out_valid 0, halted 0, state RUN, all out_* fields 0, statistics counters 0.
REQ-033 in_ready is 0 during a Reset cycle.

Configuration
REQ-034 Macro DECODE_STATS_EN: when defined, adds outputs stat_instr (16) and stat_branch (16).
REQ-035 With DECODE_STATS_EN: stat_instr increments once per handshake (out_valid && out_ready), stat_branch once per handshake with out_type B; both wrap 16'hFFFF->0; flushed bundles not counted.
REQ-036 Without DECODE_STATS_EN: ports and counters absent; all other behaviour identical.

Verification
REQ-037 Reset, then in_instr 9'b10_000_01_10 (R ADD rd1 rs2), out_ready 1 -> next cycle out_valid 1, out_type 2, out_op 0, rd 1, rs 2, reg_we 1.
REQ-038 I 9'b00_11_10000, pc 8'h05 -> out_rd 3, out_imm 8'hF0, out_pc 8'h05, reg_we 1; M STR 9'b01_01_10_11_0 -> out_op 1, mem_we 1, reg_we 0.
REQ-039 Bundle valid, out_ready 0 for 3 cycles with in_valid 1 -> in_ready 0, outputs stable; out_ready 1 -> next instruction accepted.
REQ-040 flush with valid bundle and new in_valid -> out_valid 0 next cycle, nothing accepted, stat counters unchanged.
REQ-041 Accept B FML 9'b11_111_0000 -> bundle out_op 7 presented, halted 1 next cycle, in_ready 0 until Reset pulse restores RUN.
REQ-042 DECODE_STATS_EN: 65536 handshakes of B BEQ -> stat_instr and stat_branch both wrap to 0.
